// File: rtl/fmul_pkg.sv
// Shared constants and types for the fmul arbiter slice.
package fmul_pkg;

   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } fmul_arb_state_e;

endpackage

// File: rtl/fmul.sv
// Combinational IEEE-754 binary32 multiplier: round-to-nearest-even,
// subnormal inputs and results flushed to signed zero, canonical quiet NaN.
module fmul #(
   parameter int DATA_WIDTH = 32
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] c_o
);

   // Round a 23-bit fraction to nearest-even; bit 23 of the result is the carry-out.
   function automatic logic [23:0] round_rne(input logic [22:0] frac,
                                             input logic guard,
                                             input logic sticky);
      logic up;
      up = guard & (sticky | frac[0]);
      return {1'b0, frac} + {23'd0, up};
   endfunction

   // Saturate a finite result: overflow to infinity, underflow to zero.
   function automatic logic [31:0] pack_sat(input logic sign,
                                            input logic signed [10:0] exp_s,
                                            input logic [22:0] frac);
      if (exp_s >= 11'sd255)
         return {sign, 8'hFF, 23'd0};
      else if (exp_s <= 11'sd0)
         return {sign, 31'd0};
      else
         return {sign, exp_s[7:0], frac};
   endfunction

   logic [31:0]        a, b, res;
   logic               sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic [47:0]        prod;
   logic signed [10:0] exp_s;
   logic [22:0]        frac;
   logic               guard, sticky;
   logic [23:0]        frac_r;

   assign a = a_i[31:0];
   assign b = b_i[31:0];

   // Special-case classification, significand product, normalise, round, pack.
   always_comb begin
      sign   = a[31] ^ b[31];
      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);
      prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      exp_s  = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
      if (prod[47]) begin
         frac   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
         exp_s  = exp_s + 11'sd1;
      end else begin
         frac   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      frac_r = round_rne(frac, guard, sticky);
      if (frac_r[23]) begin
         exp_s = exp_s + 11'sd1;
         frac  = 23'd0;
      end else begin
         frac  = frac_r[22:0];
      end

      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         res = 32'h7FC0_0000;
      else if (a_inf || b_inf)
         res = {sign, 8'hFF, 23'd0};
      else if (a_zero || b_zero)
         res = {sign, 31'd0};
      else
         res = pack_sat(sign, exp_s, frac);
   end

   assign c_o = DATA_WIDTH'(res);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter  int N    = 4,
   localparam int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            any_req
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      int  idx;
      logic found;
      grant     = '0;
      grant_idx = '0;
      any_req   = |req;
      found     = 1'b0;
      idx       = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin sharing of one fmul among NUM_REQ valid/ready requesters.
// Operands are registered on accept and the product is registered in CALC.
module fmul_arbiter
   import fmul_pkg::*;
#(
   parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter  int NUM_REQ    = 4,
   localparam int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b_i,
   output logic [NUM_REQ-1:0]            rsp_valid_o,
   input  logic [NUM_REQ-1:0]            rsp_ready_i,
   output logic [DATA_WIDTH-1:0]         rsp_data_o,
   output logic                          busy_o
);

   fmul_arb_state_e         state_q, state_d;
   logic [ID_W-1:0]         rr_ptr_q, owner_q;
   logic [DATA_WIDTH-1:0]   op_a_q, op_b_q, result_q, fmul_c;
   logic [NUM_REQ-1:0]      grant;
   logic [ID_W-1:0]         grant_idx;
   logic                    any_req;
   logic                    accept;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req       (req_valid_i),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   fmul #(.DATA_WIDTH(DATA_WIDTH)) u_fmul (
      .a_i (op_a_q),
      .b_i (op_b_q),
      .c_o (fmul_c)
   );

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state and handshake outputs; ready is masked while reset is held.
   always_comb begin
      state_d     = state_q;
      req_ready_o = '0;
      rsp_valid_o = '0;
      accept      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (any_req && rst_ni) begin
               req_ready_o = grant;
               accept      = 1'b1;
               state_d     = CALC;
            end
         end
         CALC: state_d = RESP;
         RESP: begin
            rsp_valid_o[owner_q] = 1'b1;
            if (rsp_ready_i[owner_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand/owner capture on accept, pointer rotation past the winner,
   // and product capture at the end of CALC.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_ptr_q <= '0;
         owner_q  <= '0;
         op_a_q   <= '0;
         op_b_q   <= '0;
         result_q <= '0;
      end else begin
         if (accept) begin
            op_a_q   <= req_a_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            op_b_q   <= req_b_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
            owner_q  <= grant_idx;
            rr_ptr_q <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         end
         if (state_q == CALC) result_q <= fmul_c;
      end
   end

   assign rsp_data_o = result_q;
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_fmul_arbiter.sv
// Scoreboard bench for fmul_arbiter: stimulus queues expected grants and
// responses; monitors pop and compare on each observed handshake.
module tb_fmul_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;

   logic             clk = 1'b0;
   logic             rst_ni;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*DW-1:0] req_a, req_b;
   logic [NR-1:0]    rsp_valid;
   logic [NR-1:0]    rsp_ready;
   logic [DW-1:0]    rsp_data;
   logic             busy;

   typedef struct {
      int          id;
      logic [31:0] data;
   } rsp_t;

   int   exp_gnt_q[$];
   rsp_t exp_rsp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   fmul_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_data_o  (rsp_data),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input bit expect_rsp);
      rsp_t r;
      req_a[id*DW +: DW] = a;
      req_b[id*DW +: DW] = b;
      req_valid[id]      = 1'b1;
      exp_gnt_q.push_back(id);
      if (expect_rsp) begin
         r.id   = id;
         r.data = res;
         exp_rsp_q.push_back(r);
      end
   endtask

   task automatic do_reset();
      rst_ni    = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_data", rsp_data, 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      tick();
      tick();
      rst_ni = 1'b1;
   endtask

   // Grant monitor: each observed grant must match the next queued requester.
   always @(negedge clk) begin
      if (rst_ni && req_ready != '0) begin
         if (exp_gnt_q.size() == 0) begin
            chk("grant_unexpected", 32'(req_ready), 32'h0);
         end else begin
            int id;
            id = exp_gnt_q.pop_front();
            chk("grant", 32'(req_ready), 32'(1) << id);
         end
      end
   end

   // Response monitor: each completed response handshake must match the queue head.
   always @(negedge clk) begin
      if (rst_ni && (rsp_valid & rsp_ready) != '0) begin
         if (exp_rsp_q.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
         end else begin
            rsp_t r;
            r = exp_rsp_q.pop_front();
            chk("rsp_owner", 32'(rsp_valid), 32'(1) << r.id);
            chk("rsp_data", rsp_data, r.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_ni    = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      req_a     = '0;
      req_b     = '0;
      do_reset();

      // Single requester: 1.0 * 2.0
      tick();
      tick();
      issue(0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b1);
      #1;
      chk("t1_ready", 32'(req_ready), 32'h1);
      chk("t1_busy_idle", 32'(busy), 32'h0);
      tick();
      req_valid[0] = 1'b0;
      #1;
      chk("t1_busy_calc", 32'(busy), 32'h1);
      chk("t1_ready_calc", 32'(req_ready), 32'h0);
      tick();
      #1;
      chk("t1_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("t1_rsp_data", rsp_data, 32'h40000000);
      chk("t1_busy_resp", 32'(busy), 32'h1);
      tick();
      #1;
      chk("t1_busy_done", 32'(busy), 32'h0);

      // Four continuous requesters: grants 0,1,2,3 every third cycle
      do_reset();
      issue(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
      issue(1, 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b1);
      issue(2, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1);
      issue(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1);
      for (int cyc = 0; cyc < 12; cyc++) begin
         #1;
         chk("t2_ready", 32'(req_ready), (cyc % 3 == 0) ? (32'(1) << (cyc / 3)) : 32'h0);
         if (cyc % 3 == 2) chk("t2_rsp_valid", 32'(rsp_valid), 32'(1) << (cyc / 3));
         tick();
         if (cyc % 3 == 0) req_valid[cyc / 3] = 1'b0;
      end
      #1;
      chk("t2_busy_done", 32'(busy), 32'h0);

      // Backpressure on requester 1's response while requester 0 waits
      do_reset();
      rsp_ready = 4'b1101;
      issue(1, 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b1);
      #1;
      chk("t3_ready1", 32'(req_ready), 32'h2);
      tick();
      req_valid[1] = 1'b0;
      issue(0, 32'h3F800000, 32'h40400000, 32'h40400000, 1'b1);
      #1;
      chk("t3_ready_calc", 32'(req_ready), 32'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t3_hold_valid", 32'(rsp_valid), 32'h2);
         chk("t3_hold_data", rsp_data, 32'hC0000000);
         chk("t3_hold_ready", 32'(req_ready), 32'h0);
         tick();
      end
      rsp_ready = '1;
      #1;
      chk("t3_release_valid", 32'(rsp_valid), 32'h2);
      tick();
      #1;
      chk("t3_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      tick();
      #1;
      chk("t3_rsp0_data", rsp_data, 32'h40400000);
      tick();

      // Requester 2, with only non-owner response readies asserted, then wrap 3 -> 0
      do_reset();
      issue(2, 32'h00000000, 32'h40000000, 32'h00000000, 1'b1);
      #1;
      chk("t4_ready2", 32'(req_ready), 32'h4);
      tick();
      req_valid[2] = 1'b0;
      tick();
      rsp_ready = 4'b1011;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("t6_valid_held", 32'(rsp_valid), 32'h4);
         chk("t6_busy_held", 32'(busy), 32'h1);
         tick();
      end
      rsp_ready = '1;
      #1;
      chk("t6_valid_release", 32'(rsp_valid), 32'h4);
      tick();
      issue(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b1);
      issue(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
      #1;
      chk("t4_ready3_first", 32'(req_ready), 32'h8);
      tick();
      req_valid[3] = 1'b0;
      tick();
      tick();
      #1;
      chk("t4_ready0_second", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      tick();
      tick();
      #1;
      chk("t4_busy_done", 32'(busy), 32'h0);

      // Asynchronous reset during CALC drops the operation
      do_reset();
      issue(0, 32'h3F800000, 32'h40000000, 32'h40000000, 1'b0);
      #1;
      chk("t5_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      #1;
      chk("t5_busy_calc", 32'(busy), 32'h1);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("t5_busy_rst", 32'(busy), 32'h0);
      chk("t5_rsp_valid_rst", 32'(rsp_valid), 32'h0);
      chk("t5_ready_rst", 32'(req_ready), 32'h0);
      tick();
      #2;
      rst_ni = 1'b1;
      issue(0, 32'h3FC00000, 32'h40000000, 32'h40400000, 1'b1);
      issue(1, 32'hBF800000, 32'h40000000, 32'hC0000000, 1'b1);
      #1;
      chk("t5_tie_ready0", 32'(req_ready), 32'h1);
      tick();
      req_valid[0] = 1'b0;
      tick();
      #1;
      chk("t5_rsp0_valid", 32'(rsp_valid), 32'h1);
      chk("t5_rsp0_data", rsp_data, 32'h40400000);
      tick();
      #1;
      chk("t5_ready1", 32'(req_ready), 32'h2);
      tick();
      req_valid[1] = 1'b0;
      tick();
      tick();
      #1;
      chk("t5_busy_done", 32'(busy), 32'h0);

      chk("grant_queue_empty", 32'(exp_gnt_q.size()), 32'h0);
      chk("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
